// File: rtl/dff_bank.sv
// dff_bank: WIDTH-bit register bank with set/clear masks, load/hold/shift/toggle modes, edge flags, saturating change counter.
// Latency: 1 edge from d/sin to q (3 edges when DFF_BANK_SYNC2_EN is defined); flags and chg_cnt track q on the same edge.
// Backpressure: none; en=0 freezes q, q_prev and chg_cnt, while cnt_clr still acts. Optional feature macro: DFF_BANK_SYNC2_EN.
module dff_bank #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             r_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic [WIDTH-1:0] s_mask,
   input  logic [WIDTH-1:0] c_mask,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_rise,
   output logic [WIDTH-1:0] q_fall,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [1:0] MODE_LOAD   = 2'b00;
   localparam logic [1:0] MODE_HOLD   = 2'b01;
   localparam logic [1:0] MODE_SHIFT  = 2'b10;
   localparam logic [1:0] MODE_TOGGLE = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] d_use;
   logic             sin_use;
   logic [WIDTH-1:0] mode_val;
   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] q_prev;
   logic             upd;

`ifdef DFF_BANK_SYNC2_EN
   logic [WIDTH-1:0] d_s1, d_s2;
   logic             sin_s1, sin_s2;

   // two-flop synchronisers on the data inputs; they shift every edge regardless of en
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         d_s1   <= '0;
         d_s2   <= '0;
         sin_s1 <= 1'b0;
         sin_s2 <= 1'b0;
      end else begin
         d_s1   <= d;
         d_s2   <= d_s1;
         sin_s1 <= sin;
         sin_s2 <= sin_s1;
      end
   end

   assign d_use   = d_s2;
   assign sin_use = sin_s2;
`else
   assign d_use   = d;
   assign sin_use = sin;
`endif

   // mode result for every bit, then masks override bit-by-bit (clear beats set)
   always_comb begin
      mode_val = q;
      case (mode)
         MODE_LOAD:   mode_val = d_use;
         MODE_HOLD:   mode_val = q;
         MODE_SHIFT:  mode_val = {q[WIDTH-2:0], sin_use};
         MODE_TOGGLE: mode_val = q ^ d_use;
         default:     mode_val = q;
      endcase
      next_q = (mode_val | s_mask) & ~c_mask;
   end

   // main register plus the previous-value copy used for edge detection
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         q      <= RST_VAL;
         q_prev <= RST_VAL;
      end else if (en) begin
         q      <= next_q;
         q_prev <= q;
      end
   end

   // remembers whether the last edge was an update edge; a frozen edge must not
   // re-report the previous transition even though q_prev is held
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) upd <= 1'b0;
      else      upd <= en;
   end

   // change counter: clear has priority, increments only on real changes, saturates at all-ones
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n)
         chg_cnt <= '0;
      else if (cnt_clr)
         chg_cnt <= '0;
      else if (en && (next_q != q) && (chg_cnt != CNT_MAX))
         chg_cnt <= chg_cnt + 1'b1;
   end

   // edge flags come only from registers, so there is no input-to-output path
   always_comb begin
      q_rise = (q & ~q_prev) & {WIDTH{upd}};
      q_fall = (~q & q_prev) & {WIDTH{upd}};
   end

endmodule

// File: tb/tb_dff_bank.sv
// tb_dff_bank: directed-vector bench for dff_bank with hand-computed expectations.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_dff_bank;

   logic       clk;
   logic       r_n;
   logic       en;
   logic [1:0] mode;
   logic [7:0] d;
   logic       sin;
   logic [7:0] s_mask;
   logic [7:0] c_mask;
   logic       cnt_clr;
   logic [7:0] q, q_rise, q_fall, chg_cnt;
   logic [7:0] q2, q2_rise, q2_fall;
   logic [1:0] chg_cnt2;

   int n_vec = 0;
   int n_err = 0;

   dff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(8)) u_dut (
      .clk(clk), .r_n(r_n), .en(en), .mode(mode), .d(d), .sin(sin),
      .s_mask(s_mask), .c_mask(c_mask), .cnt_clr(cnt_clr),
      .q(q), .q_rise(q_rise), .q_fall(q_fall), .chg_cnt(chg_cnt)
   );

   dff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(2)) u_sat (
      .clk(clk), .r_n(r_n), .en(en), .mode(mode), .d(d), .sin(sin),
      .s_mask(s_mask), .c_mask(c_mask), .cnt_clr(cnt_clr),
      .q(q2), .q_rise(q2_rise), .q_fall(q2_fall), .chg_cnt(chg_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      r_n = 1'b0;
      step();
      step();
      r_n = 1'b1;
   endtask

   initial begin
      r_n = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00; sin = 1'b0;
      s_mask = 8'h00; c_mask = 8'h00; cnt_clr = 1'b0;
      #3;
      chk("rst_q",    32'(q), 32'h00);
      chk("rst_rise", 32'(q_rise), 32'h00);
      chk("rst_fall", 32'(q_fall), 32'h00);
      chk("rst_cnt",  32'(chg_cnt), 32'h00);
      do_reset();

`ifdef DFF_BANK_SYNC2_EN
      // d passes two synchroniser flops before q: visible on the third edge
      en = 1'b1; mode = 2'b00; d = 8'h00;
      repeat (3) step();
      chk("sync_q0", 32'(q), 32'h00);
      d = 8'h55;
      step();
      chk("sync_e1", 32'(q), 32'h00);
      step();
      chk("sync_e2", 32'(q), 32'h00);
      step();
      chk("sync_e3", 32'(q), 32'h55);
      chk("sync_rise", 32'(q_rise), 32'h55);
      chk("sync_cnt", 32'(chg_cnt), 32'h01);
`else
      // load and edge flags
      en = 1'b1; mode = 2'b00; d = 8'h0F;
      step();
      chk("ld1_q",    32'(q), 32'h0F);
      chk("ld1_rise", 32'(q_rise), 32'h0F);
      chk("ld1_fall", 32'(q_fall), 32'h00);
      d = 8'hF0;
      step();
      chk("ld2_q",    32'(q), 32'hF0);
      chk("ld2_rise", 32'(q_rise), 32'hF0);
      chk("ld2_fall", 32'(q_fall), 32'h0F);
      chk("ld2_cnt",  32'(chg_cnt), 32'h02);

      // mask priority over toggle; bit 2 has both masks, clear wins
      d = 8'h00;
      step();
      chk("mk_pre_q", 32'(q), 32'h00);
      mode = 2'b11; d = 8'hFF; s_mask = 8'h0C; c_mask = 8'h06;
      step();
      chk("mk_q",   32'(q), 32'hF9);
      chk("mk_cnt", 32'(chg_cnt), 32'h04);
      s_mask = 8'h00; c_mask = 8'h00;

      // shift with msb discarded, then hold
      mode = 2'b00; d = 8'h81;
      step();
      mode = 2'b10; sin = 1'b1;
      step();
      chk("sh_q",   32'(q), 32'h03);
      chk("sh_cnt", 32'(chg_cnt), 32'h06);
      mode = 2'b01; sin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_q", 32'(q), 32'h03);
      end
      chk("hold_cnt",  32'(chg_cnt), 32'h06);
      chk("hold_rise", 32'(q_rise), 32'h00);

      // en=0 freezes q and counter
      en = 1'b0; mode = 2'b00; d = 8'hAA;
      step();
      chk("en0_q",   32'(q), 32'h03);
      chk("en0_cnt", 32'(chg_cnt), 32'h06);

      // asynchronous reset mid-cycle with q=A5
      en = 1'b1; d = 8'hA5;
      step();
      chk("pre_rst_q", 32'(q), 32'hA5);
      #2 r_n = 1'b0;
      #1;
      chk("arst_q",    32'(q), 32'h00);
      chk("arst_rise", 32'(q_rise), 32'h00);
      chk("arst_fall", 32'(q_fall), 32'h00);
      chk("arst_cnt",  32'(chg_cnt), 32'h00);
      step();
      r_n = 1'b1;

      // saturation on the 2-bit counter, then clear
      mode = 2'b11; d = 8'h01;
      for (int i = 0; i < 5; i++) step();
      chk("sat_q",    32'(q2), 32'h01);
      chk("sat_cnt2", 32'(chg_cnt2), 32'h3);
      chk("sat_cnt8", 32'(chg_cnt), 32'h05);
      cnt_clr = 1'b1;
      step();
      chk("clr_cnt2", 32'(chg_cnt2), 32'h0);
      chk("clr_cnt8", 32'(chg_cnt), 32'h00);
      chk("clr_q",    32'(q), 32'h00);
      cnt_clr = 1'b0;

      // cnt_clr still acts while en=0
      step();
      chk("inc_cnt", 32'(chg_cnt), 32'h01);
      en = 1'b0; cnt_clr = 1'b1;
      step();
      chk("clr_en0_cnt", 32'(chg_cnt), 32'h00);
      chk("clr_en0_q",   32'(q), 32'h01);
      cnt_clr = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dff_bank.md
# dff_bank

Parametrised successor to the single D flip-flop: a WIDTH-bit register bank with synchronous per-bit set/clear masks and four update modes (load, hold, shift, toggle). It also has per-bit edge flags and a saturating change counter. It sits between the lab's stimulus logic and downstream observers, replacing banks of individual set/reset flops.

## Interface
- WIDTH, 8, register width in bits (≥2)
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 8, change-counter width (≥1)

- clk  in  1  clock; rising edge active
- r_n  in  1  reset; asynchronous assert, active-low; release synchronous to clk upstream
- en  in  1  update enable; 0 = q holds, masks included
- mode  in  2  00 load d, 01 hold, 10 shift left (sin → bit 0), 11 toggle bits where d=1
- d  in  WIDTH  data / toggle mask
- sin  in  1  serial input for shift mode
- s_mask  in  WIDTH  per-bit synchronous set
- c_mask  in  WIDTH  per-bit synchronous clear
- cnt_clr  in  1  synchronous clear of chg_cnt
- q  out  WIDTH  register value
- q_rise  out  WIDTH  bits that went 0→1 on the last edge
- q_fall  out  WIDTH  bits that went 1→0 on the last edge
- chg_cnt  out  CNT_W  number of edges on which q changed; saturating

## Operation
- Reset (r_n=0), asynchronous and immediate:
  - q = RST_VAL.
  - q_prev = RST_VAL, so q_rise = q_fall = 0.
  - chg_cnt = 0.
- Per bit i at the rising edge with en=1, highest priority first:
  1. c_mask[i]=1 → q[i]=0.
  2. s_mask[i]=1 → q[i]=1.
  3. Otherwise apply mode:
     - load: q[i]=d[i]
     - hold: q[i] unchanged
     - shift: q[i]=q[i-1], q[0]=sin, q[WIDTH-1] is discarded
     - toggle: q[i]=q[i]^d[i]
- Simultaneous s_mask and c_mask on the same bit: clear wins.
- Masks override mode bit-by-bit; unmasked bits still follow mode in the same cycle.
- en=0: q, q_prev and chg_cnt all hold, so edge flags read 0 from the next cycle. cnt_clr still acts.
- q_prev is a register loaded with q every edge while en=1. Edge flags are combinational from it:
  - q_rise = q & ~q_prev
  - q_fall = ~q & q_prev
- chg_cnt at each edge:
  - cnt_clr=1 → 0. cnt_clr takes priority over increment.
  - else if en=1, next_q≠q and chg_cnt<2^CNT_W−1 → +1.
  - At 2^CNT_W−1 the counter saturates; it does not wrap.
- Edges that produce no change (hold, or load of the same value) do not count.

## Timing
- Latency: an input sampled at edge N is visible on q after edge N. q_rise/q_fall are valid in the same cycle.
- Edge flags are pulses: one cycle wide unless q changes again on the next edge.
- chg_cnt updates on the same edge as q.
- Reset mid-operation:
  - All outputs return to reset values within the same cycle, independent of clk.
  - First update occurs on the first rising edge with r_n=1.
- No combinational path from any input to any output. Only r_n has an asynchronous path.

## Configuration
- DFF_BANK_SYNC2_EN defined:
  - d and sin each pass through a 2-flop synchroniser, reset to 0, before use.
  - Load, toggle and shift latency from d/sin to q becomes 3 edges.
  - mode, masks, en and cnt_clr are unaffected.
  - Synchroniser flops shift every edge regardless of en.
- DFF_BANK_SYNC2_EN undefined: d/sin are used directly, with 1-edge latency as above.

## Test plan
Defaults WIDTH=8, RST_VAL=0, CNT_W=8, macro undefined unless stated.
- Reset: r_n=0 mid-cycle with q=0xA5 → q=0x00, q_rise=q_fall=0, chg_cnt=0 immediately, without a clk edge.
- Load/edges: en=1, mode=00, d=0x0F then d=0xF0 →
  - q=0x0F with q_rise=0x0F.
  - Then q=0xF0 with q_rise=0xF0, q_fall=0x0F.
  - chg_cnt=2.
- Mask priority: q=0x00, mode=11, d=0xFF, s_mask=0x0C, c_mask=0x06 → q=0xF9 (bit 1, 2 clear; bit 3 set; others toggled).
- Shift/hold: q=0x81, mode=10, sin=1 → q=0x03. Then mode=01 for 3 edges → q=0x03, chg_cnt unchanged.
- Saturation/clear (CNT_W=2): toggle d=0x01 for 5 edges → chg_cnt=3. Then cnt_clr=1 with toggle → chg_cnt=0.
- DFF_BANK_SYNC2_EN: mode=00, d steps 0x00→0x55 → q=0x55 exactly 3 edges after d changes.
